// File: rtl/stopwatch_timebase_ctrl_pkg.sv
// Shared definitions for the stopwatch control/timebase slice:
// FSM encodings, board timing defaults and a counter-width helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int BOARD_CLK_HZ            = 50_000_000;
    localparam int DEFAULT_TICK_DIV        = 500_000;   // 100 Hz timebase
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;   // 10 ms debounce

    localparam int NUM_BUTTONS    = 2;
    localparam int BTN_START_STOP = 0;
    localparam int BTN_CLEAR      = 1;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_timebase_ctrl_if.sv
// Button inputs and counter-chain control outputs of the timebase stage.
// The slave side is the controller; the master side drives the buttons.
interface stopwatch_timebase_ctrl_if;
    logic BtnStartStop;
    logic BtnClear;
    logic Tick;
    logic ClearCounters;
    logic Running;

    modport master (
        output BtnStartStop,
        output BtnClear,
        input  Tick,
        input  ClearCounters,
        input  Running
    );

    modport slave (
        input  BtnStartStop,
        input  BtnClear,
        output Tick,
        output ClearCounters,
        output Running
    );
endinterface

// File: rtl/stopwatch_timebase_ctrl_debouncer.sv
// One push-button path: 2-flop synchronizer, stable-level debounce and a
// single-cycle pulse on each accepted press (release gives no pulse).
module button_debouncer
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic BtnRaw,
    output logic Level,
    output logic Press
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    // Bring the raw button into the Clock domain.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= BtnRaw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it differs for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_level_d <= 1'b0;
        else       r_level_d <= r_level;
    end

    assign Level = r_level;
    assign Press = r_level & ~r_level_d;

endmodule

// File: rtl/stopwatch_timebase_ctrl.sv
// Run/pause/idle control and centisecond timebase for the stopwatch digit
// chain: debounced buttons drive the FSM, a prescaler advancing only in RUN
// produces Tick, and clear requests produce a one-cycle ClearCounters.
module stopwatch_timebase_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                       Clock,
    input  logic                       Reset,
    stopwatch_timebase_ctrl_if.slave   bus
);

    localparam int               PRE_W    = cnt_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [NUM_BUTTONS-1:0] w_btn_raw;
    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_press;
    logic                   w_press_ss;
    logic                   w_press_clr;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PRE_W-1:0]       r_presc;
    logic                   r_clear;
    logic                   r_running;
    logic                   w_tick;
    logic                   w_clear_next;
    logic                   w_running_next;

    assign w_btn_raw[BTN_START_STOP] = bus.BtnStartStop;
    assign w_btn_raw[BTN_CLEAR]      = bus.BtnClear;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .Clock  (Clock),
                .Reset  (Reset),
                .BtnRaw (w_btn_raw[gi]),
                .Level  (w_level[gi]),
                .Press  (w_press[gi])
            );
        end
    endgenerate

    assign w_press_ss  = w_press[BTN_START_STOP];
    assign w_press_clr = w_press[BTN_CLEAR];

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: start/stop toggles RUN/PAUSE; clear only acts out of PAUSE
    // (and wins there over a simultaneous start/stop).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_press_ss) w_state_next = ST_RUN;
            ST_RUN:   if (w_press_ss) w_state_next = ST_PAUSE;
            ST_PAUSE: begin
                if (w_press_clr)     w_state_next = ST_IDLE;
                else if (w_press_ss) w_state_next = ST_RUN;
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: Tick straight from registers; clear and running are pre-computed
    // here and registered below.
    always_comb begin
        w_tick         = (r_state == ST_RUN) && (r_presc == PRE_LAST);
        w_clear_next   = w_press_clr && ((r_state == ST_IDLE) || (r_state == ST_PAUSE));
        w_running_next = (w_state_next == ST_RUN);
    end

    // Prescaler: advances in RUN, holds in PAUSE so resume keeps the partial
    // tick, and is zeroed whenever the FSM is (or is about to be) IDLE.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_presc <= '0;
        end else if (w_state_next == ST_IDLE) begin
            r_presc <= '0;
        end else if (r_state == ST_RUN) begin
            r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
        end
    end

    // Registered ClearCounters pulse and Running flag.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_clear   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_clear   <= w_clear_next;
            r_running <= w_running_next;
        end
    end

    assign bus.Tick          = w_tick;
    assign bus.ClearCounters = r_clear;
    assign bus.Running       = r_running;

endmodule

// File: tb/tb_stopwatch_timebase_ctrl.sv
// Scoreboard bench: each button action pushes the output events it must
// cause (Running edges, Tick, ClearCounters) with their expected cycle; a
// monitor on the falling edge pops and compares every event the DUT makes.
module tb_stopwatch_timebase_ctrl;

    localparam int TD = 10;   // TICK_DIV
    localparam int DB = 4;    // DEBOUNCE_CYCLES
    localparam int LAT = DB + 2;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_TICK = 2;
    localparam int K_CLR  = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic Clock;
    logic Reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 0;
    bit   prev_run = 0;
    ev_t  exp_q[$];

    stopwatch_timebase_ctrl_if bus();

    stopwatch_timebase_ctrl #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("[TB] ok %s = %0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic push(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int kind, input string name);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].kind == kind) idx = i;
        if (idx < 0) begin
            chk({name, "_unexpected"}, cyc, -1);
        end else begin
            chk(name, cyc, exp_q[idx].cyc);
            exp_q.delete(idx);
        end
    endtask

    // Monitor: every output event is checked against the scoreboard.
    always @(negedge Clock) begin
        if (Reset || !mon_en) begin
            prev_run = 1'b0;
        end else begin
            if (bus.Running && !prev_run) match_ev(K_RISE, "running_rise");
            if (!bus.Running && prev_run) match_ev(K_FALL, "running_fall");
            if (bus.Tick) begin
                match_ev(K_TICK, "tick");
                chk("tick_vs_clear", int'(bus.ClearCounters), 0);
                chk("tick_in_run", int'(bus.Running), 1);
            end
            if (bus.ClearCounters) match_ev(K_CLR, "clear");
            prev_run = bus.Running;
        end
    end

    // Press buttons at the current falling edge; k is the first sampling edge.
    task automatic btn_down(input bit ss, input bit cl, output int k);
        bus.BtnStartStop = ss;
        bus.BtnClear     = cl;
        k = cyc + 1;
    endtask

    task automatic btn_hold_release(input int hold);
        repeat (hold) @(negedge Clock);
        bus.BtnStartStop = 1'b0;
        bus.BtnClear     = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge Clock);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, r;
        Reset = 1'b1;
        bus.BtnStartStop = 1'b0;
        bus.BtnClear     = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_tick",    int'(bus.Tick), 0);
        chk("rst_clear",   int'(bus.ClearCounters), 0);
        chk("rst_running", int'(bus.Running), 0);
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Idle with no buttons: monitor must see no events.
        repeat (100) @(negedge Clock);
        chk("idle_running", int'(bus.Running), 0);

        // Short glitch on start/stop: rejected.
        btn_down(1, 0, k);
        btn_hold_release(3);
        repeat (20) @(negedge Clock);
        chk("glitch_running", int'(bus.Running), 0);

        // Clear in IDLE: one ClearCounters pulse, stays IDLE.
        btn_down(0, 1, k);
        push(K_CLR, k + LAT);
        btn_hold_release(6);
        repeat (20) @(negedge Clock);
        chk("idle_clear_running", int'(bus.Running), 0);

        // Long hold of start/stop: single press, ticks every TD cycles.
        btn_down(1, 0, k);
        r = k + LAT;
        push(K_RISE, r);
        push(K_TICK, r + TD - 1);
        push(K_TICK, r + 2*TD - 1);
        push(K_TICK, r + 3*TD - 1);
        btn_hold_release(20);
        // Pause after 35 running cycles: prescaler keeps 5.
        wait_cyc(r + 28);
        btn_down(1, 0, k);
        push(K_FALL, k + LAT);
        btn_hold_release(6);
        wait_cyc(r + 55);
        chk("pause_running", int'(bus.Running), 0);
        // Resume: first tick on the 5th running cycle.
        btn_down(1, 0, k);
        r = k + LAT;
        push(K_RISE, r);
        push(K_TICK, r + 4);
        push(K_TICK, r + 14);
        push(K_TICK, r + 24);
        btn_hold_release(6);
        // Clear while running: ignored.
        wait_cyc(r + 4);
        btn_down(0, 1, k);
        btn_hold_release(6);
        // Pause again after 26 running cycles.
        wait_cyc(r + 19);
        btn_down(1, 0, k);
        push(K_FALL, k + LAT);
        btn_hold_release(6);
        // Both buttons in PAUSE: clear wins, back to IDLE.
        wait_cyc(r + 45);
        btn_down(1, 1, k);
        push(K_CLR, k + LAT);
        btn_hold_release(6);
        repeat (20) @(negedge Clock);
        chk("pause_both_running", int'(bus.Running), 0);

        // From IDLE (prescaler 0): 25 running cycles, then pause holds 5.
        btn_down(1, 0, k);
        r = k + LAT;
        push(K_RISE, r);
        push(K_TICK, r + 9);
        push(K_TICK, r + 19);
        btn_hold_release(6);
        wait_cyc(r + 18);
        btn_down(1, 0, k);
        push(K_FALL, r + 25);
        btn_hold_release(6);
        wait_cyc(r + 45);
        btn_down(1, 0, k);
        r = k + LAT;
        push(K_RISE, r);
        push(K_TICK, r + 4);
        btn_hold_release(6);
        // Both buttons in RUN: start/stop wins, no clear. Prescaler ends at 7.
        wait_cyc(r + 5);
        btn_down(1, 1, k);
        push(K_FALL, k + LAT);
        btn_hold_release(6);
        wait_cyc(r + 35);
        btn_down(1, 0, k);
        r = k + LAT;
        push(K_RISE, r);
        push(K_TICK, r + 2);
        push(K_TICK, r + 12);
        btn_hold_release(6);

        // Asynchronous reset in the middle of a Tick cycle.
        wait_cyc(r + 12);
        #1;
        chk("tick_before_reset", int'(bus.Tick), 1);
        Reset = 1'b1;
        #1;
        chk("async_rst_tick",    int'(bus.Tick), 0);
        chk("async_rst_running", int'(bus.Running), 0);
        repeat (3) @(negedge Clock);
        #1 Reset = 1'b0;
        repeat (10) @(negedge Clock);
        chk("post_rst_running", int'(bus.Running), 0);
        // IDLE after reset: start gives first tick on the 10th running cycle.
        btn_down(1, 0, k);
        r = k + LAT;
        push(K_RISE, r);
        push(K_TICK, r + TD - 1);
        btn_hold_release(6);
        wait_cyc(r + TD + 2);

        chk("scoreboard_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_timebase_ctrl.md
# stopwatch_timebase_ctrl

Upstream control and timebase stage of the VGA stopwatch. Turns two raw push-buttons (start/stop, clear) into a run/pause/idle state machine and derives a one-cycle `Tick` enable that drives the `Enable` input of the first digit counter in the counter chain. It also emits a one-cycle `ClearCounters` pulse that the chain uses to zero all digits.

## Interface
- `TICK_DIV`, default 500000: clock cycles per `Tick` (50 MHz → 100 Hz, centiseconds).
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button level change (10 ms).

- `Clock`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high.
- `BtnStartStop`  in  1  raw button, asynchronous to `Clock`, active-high.
- `BtnClear`  in  1  raw button, asynchronous, active-high.
- `Tick`  out  1  one-cycle enable to the digit counter chain.
- `ClearCounters`  out  1  one-cycle synchronous clear to the digit counter chain.
- `Running`  out  1  high while in RUN.

## Operation
- **Button path (per button):**
  - 2-flop synchronizer, then debounce.
  - Debounce counter increments while the synchronized value differs from the debounced level, and clears when they are equal.
  - On the edge where the counter would reach `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
  - Press pulse = debounced level high and its 1-cycle-delayed copy low. Exactly one pulse per accepted press; holding a button gives no repeats.
  - Releases are debounced identically and produce no pulse.
- **FSM states:** IDLE (reset state), RUN, PAUSE.
  - IDLE: start/stop press → RUN. Clear press → `ClearCounters` pulse, stay IDLE.
  - RUN: start/stop press → PAUSE. Clear press ignored.
  - PAUSE: start/stop press → RUN. Clear press → IDLE with `ClearCounters` pulse.
  - Both presses in the same cycle: in PAUSE, clear wins (→ IDLE). In RUN, start/stop wins (→ PAUSE). In IDLE, go to RUN and still pulse `ClearCounters`.
- **Prescaler:**
  - Width `$clog2(TICK_DIV)`; counts only in RUN.
  - At count `TICK_DIV-1` in RUN: `Tick` is high for that cycle and the count wraps to 0.
  - Holds its value in PAUSE, so resume keeps the fractional tick.
  - Forced to 0 in IDLE.
- **Output registering:**
  - `Tick` is combinational from the registered prescaler and state, so it is glitch-free.
  - `ClearCounters` and `Running` are registered.

## Timing
- **Reset values:** state IDLE, prescaler 0, synchronizers 0, debounced levels 0, debounce counters 0, `Tick` 0, `ClearCounters` 0, `Running` 0.
- **Reset mid-operation:** all outputs drop immediately, without waiting for `Clock`.
- **Button latency:**
  - Input high first sampled at edge k → press pulse high in the cycle following edge k+1+`DEBOUNCE_CYCLES`.
  - State and `Running` update at edge k+2+`DEBOUNCE_CYCLES`.
  - `ClearCounters` is high for exactly the cycle after that same edge.
- **Glitches:** a level held for fewer than `DEBOUNCE_CYCLES` synchronized cycles produces no press.
- **Tick spacing:**
  - First `Tick` from IDLE→RUN is the `TICK_DIV`-th cycle with `Running` high.
  - Subsequent ticks are exactly `TICK_DIV` cycles apart while in RUN.
  - `Tick` is never high outside RUN.
- **Clear vs. Tick:** `Tick` and `ClearCounters` are never high in the same cycle.

## Structure
- **Shared package `stopwatch_pkg`:**
  - State encodings: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - Default `TICK_DIV` and `DEBOUNCE_CYCLES` constants.
  - Board clock frequency.
- **Sub-module `button_debouncer`:** synchronizer, debounce counter and rising-edge pulse. Parameter `DEBOUNCE_CYCLES`; ports `Clock`, `Reset`, `BtnRaw`, `Level`, `Press`. Instantiated twice.
- **Top level:** FSM, prescaler and output registers.

## Test plan
All scenarios use `TICK_DIV`=10, `DEBOUNCE_CYCLES`=4.
- Release `Reset`, no buttons for 100 cycles → `Tick`, `ClearCounters`, `Running` all stay 0.
- Hold `BtnStartStop` high for 20 cycles from edge k → `Running` rises at edge k+6 and stays high (single press); `Tick` pulses at the 10th, 20th, 30th `Running` cycle.
- 3-cycle pulse on `BtnStartStop` while IDLE → no state change, no `Tick`.
- In RUN for 25 cycles (2 ticks), then press start/stop → PAUSE, prescaler holds 5. Press again → next `Tick` 5 cycles after `Running` re-asserts.
- Press `BtnClear` in RUN → ignored, ticks continue. Then in PAUSE press both buttons together → one `ClearCounters` cycle, state IDLE, `Running` 0, prescaler 0.
- Assert `Reset` between clock edges mid-RUN, coincident with a `Tick` cycle → `Tick` and `Running` fall without a clock edge. After release, the FSM is in IDLE.
